au_gray_counter: RTL
====================

Name: au_gray_counter

Overview:
- Registered, parametrised up/down counter that presents its state as both binary and reflected Gray code.
- Serves as the sequential successor to the combinational binary-to-Gray converter in the arithmetic-unit library.
- Used for pointers that cross clock domains, such as async FIFO read/write pointers, and for low-toggle position counters.
- Adds: enable, direction, synchronous clear, parallel load in either code, and a wrap or saturate mode with a terminal-count flag.

Parameters:
- WIDTH, 8, counter word length in bits; legal range 2..32.
- WRAP, 1, overflow mode: 1 = modulo 2^WIDTH wrap-around; 0 = saturate at 0 / 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous clear to zero.
- ld  input  1  synchronous parallel load of d.
- ld_gray  input  1  code of d during load: 1 = d is Gray, 0 = d is binary.
- d  input  WIDTH  load value.
- en  input  1  count enable.
- dn  input  1  direction: 0 = increment, 1 = decrement.
- b  output  WIDTH  registered count, binary.
- g  output  WIDTH  registered count, Gray; always equals b ^ (b >> 1).
- tc  output  1  registered terminal-count flag, single-cycle per event.

Behaviour:
- Reset: rst=1 forces b=0, g=0, tc=0 immediately, independent of clk. Outputs are held while rst=1. Counting resumes on the first rising edge after deassertion.
- All other updates occur on rising clk edges. Priority is clr > ld > en. When none of these is active, b and g hold and tc=0.
- clr: b=0, g=0, tc=0 on the next edge. The value of d is ignored.
- ld with ld_gray=0: b=d, g=d^(d>>1).
- ld with ld_gray=1: g=d, b=gray2bin(d), where b[WIDTH-1]=d[WIDTH-1] and b[i]=b[i+1]^d[i].
- tc=0 after any load.
- en=1, dn=0, count below max: b=b+1.
- en=1, dn=1, count above 0: b=b-1.
- g is always derived from the next binary value and registered in the same edge as b. Latency from control input to output is 1 cycle; there is no combinational path from inputs to outputs.
- Boundary, WRAP=1: increment at max (2^WIDTH-1) gives b=0, g=0. Decrement at 0 gives b=max, g=1<<(WIDTH-1). tc=1 for the edge that performs the wrap; otherwise tc=0.
- Boundary, WRAP=0: increment at max or decrement at 0 leaves b and g unchanged, and tc=1. tc stays 1 on every enabled cycle that is blocked, and is 0 once the counter moves or en=0.
- Invariant: successive g values produced by counting, including wrap, differ in exactly one bit. Clear and load are exempt.
- dn may change on any cycle. The next edge uses the current dn with no turnaround penalty.
- The arithmetic is WIDTH-bit unsigned. No intermediate result exceeds WIDTH+1 bits; the carry/borrow bit is used only to detect terminal count.

Decomposition:
- Shared package au_gray_pkg:
  - functions f_bin2gray and f_gray2bin, parametrised by WIDTH through a typed argument.
  - the localparam computing the max value from WIDTH.
- One sub-module, au_gray_count_next: purely combinational. It takes the current b plus ctrl and produces the next b, next g and the terminal-count event.
- The top level holds only the registers and the reset logic.
- The existing combinational binary-to-Gray block may be instantiated inside au_gray_count_next instead of calling the function.

Test Plan (WIDTH=4 unless noted):
- Reset, then en=1, dn=0 for 17 cycles:
  - g steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1.
  - Exactly one bit changes per step.
  - tc=1 only on the 8->0 transition, where b goes 15->0.
- Load Gray: ld=1, ld_gray=1, d=4'hC -> b=8, g=C, tc=0. Then en=1, dn=1 for 1 cycle -> b=7, g=4.
- Wrap downward: clr, then en=1, dn=1 -> b=15, g=8, tc=1. On the following cycle b=14, g=9, tc=0.
- WRAP=0: load binary d=14, then en=1, dn=0 for 3 cycles:
  - b goes 15, 15, 15.
  - tc goes 0, 1, 1.
  - Then en=0 -> tc=0 and b stays 15.
- Priority: clr=1, ld=1, d=5, en=1 on the same edge -> b=0, g=0. Then ld=1, en=1, d=5 -> b=5, g=7 (load wins over count).
- Async reset mid-count: at b=9, assert rst between edges -> b, g and tc are 0 before the next edge. Deassert, then en=1 -> b=1 on the first edge.
- WIDTH=16 random: 10000 random sequences of clr/ld/ld_gray/en/dn/d, checked against a behavioural model. g must equal b^(b>>1) every cycle.

Source files
------------

// File: rtl/au_gray_pkg.sv
// Shared types and code-conversion helpers for the Gray-code counter family.
// Helpers work on a 32-bit word; narrower callers zero-extend and truncate.
package au_gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  typedef struct packed {
    logic clr;
    logic ld;
    logic ld_gray;
    logic en;
    logic dn;
  } ctrl_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_e;

  // All-ones value for a counter of the given width.
  function automatic word_t f_max_val(input int unsigned width);
    word_t m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic word_t f_bin2gray(input word_t v);
    return v ^ (v >> 1);
  endfunction

  // Zero-extended upper bits stay zero, so the MSB of a narrower word is
  // reproduced unchanged, as the conversion requires.
  function automatic word_t f_gray2bin(input word_t v);
    word_t r;
    r = '0;
    r[MAX_WIDTH-1] = v[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/au_gray_count_next.sv
// Combinational next-state logic: priority decode, wrap/saturate arithmetic,
// Gray encoding of the next value and the terminal-count event.
module au_gray_count_next
  import au_gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] b,
  input  ctrl_t            ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] b_next,
  output logic [WIDTH-1:0] g_next,
  output logic             tc_next
);

  localparam logic [WIDTH-1:0] MAX_B = WIDTH'(f_max_val(WIDTH));

  logic [WIDTH:0]   inc_w;
  logic [WIDTH:0]   dec_w;
  logic             carry;
  logic             borrow;
  logic [WIDTH-1:0] load_b;
  op_e              op;

  // The extra bit only flags the wrap; the count itself stays WIDTH bits.
  assign inc_w  = {1'b0, b} + (WIDTH+1)'(1);
  assign dec_w  = {1'b0, b} - (WIDTH+1)'(1);
  assign carry  = inc_w[WIDTH];
  assign borrow = dec_w[WIDTH];

  assign load_b = ctrl.ld_gray ? WIDTH'(f_gray2bin(word_t'(d))) : d;

  always_comb begin
    op = OP_HOLD;
    if (ctrl.clr)     op = OP_CLR;
    else if (ctrl.ld) op = OP_LOAD;
    else if (ctrl.en) op = ctrl.dn ? OP_DEC : OP_INC;
  end

  always_comb begin
    b_next  = b;
    tc_next = 1'b0;
    case (op)
      OP_CLR:  b_next = '0;
      OP_LOAD: b_next = load_b;
      OP_INC: begin
        tc_next = carry;
        if (carry && (WRAP == 0)) b_next = MAX_B;
        else                      b_next = inc_w[WIDTH-1:0];
      end
      OP_DEC: begin
        tc_next = borrow;
        if (borrow && (WRAP == 0)) b_next = '0;
        else                       b_next = dec_w[WIDTH-1:0];
      end
      default: b_next = b;
    endcase
  end

  assign g_next = WIDTH'(f_bin2gray(word_t'(b_next)));

endmodule

// File: rtl/au_gray_counter.sv
// Registered up/down counter presenting its state in binary and Gray code.
// Only the state registers live here; all next-state logic is in the sub-block.
module au_gray_counter
  import au_gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             ld_gray,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             tc
);

  ctrl_t            ctrl;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] g_q;
  logic             tc_q;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_next;
  logic             tc_next;

  always_comb begin
    ctrl         = '0;
    ctrl.clr     = clr;
    ctrl.ld      = ld;
    ctrl.ld_gray = ld_gray;
    ctrl.en      = en;
    ctrl.dn      = dn;
  end

  au_gray_count_next #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_next (
    .b       (b_q),
    .ctrl    (ctrl),
    .d       (d),
    .b_next  (b_next),
    .g_next  (g_next),
    .tc_next (tc_next)
  );

  // g is registered alongside b so both codes change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q  <= '0;
      g_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      b_q  <= b_next;
      g_q  <= g_next;
      tc_q <= tc_next;
    end
  end

  assign b  = b_q;
  assign g  = g_q;
  assign tc = tc_q;

endmodule
